// File: rtl/comb_decimator.sv
`default_nettype none
// ============================================================================
// Module      : comb_decimator
// Description : Differentiating, decimating comb stage. Keeps every R-th
//               accepted input word and outputs the difference between that
//               word and the word kept M decimated periods earlier (mod 2^W).
//               Paired with an upstream accumulator it forms the comb half of
//               a one-stage CIC decimator.
//
// Parameters  : W - data width (input and output)
//               R - decimation ratio, R >= 1
//               M - differential delay in decimated samples, 1..4
//
// Ports       : clk       - sole clock, rising edge
//               reset_n   - asynchronous active-low reset
//               clear     - synchronous restart of phase counter and delay line
//               in_valid  - qualifies `in` for one cycle
//               in        - integrated sample, modulo 2^W
//               out_valid - registered single-cycle pulse per decimated output
//               out       - registered difference, held between pulses
//
// Revision    : 1.0 - initial release
// ============================================================================
module comb_decimator #(
    parameter int W = 32,
    parameter int R = 4,
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in,
    output logic         out_valid,
    output logic [W-1:0] out
);

    // A one-bit counter is kept even for R=1; it simply never leaves 0.
    localparam int                    c_PHASE_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [c_PHASE_W-1:0] c_LAST    = c_PHASE_W'(R - 1);

    logic [c_PHASE_W-1:0] r_phase;
    logic [W-1:0]         r_dly [M];
    logic [W-1:0]         r_out;
    logic                 r_out_valid;
    logic                 w_keep;

    // The keep cycle is the R-th accepted word since the last restart.
    assign w_keep = in_valid && (r_phase == c_LAST);

    // Phase counter: only accepted words advance it, so gaps in in_valid
    // leave the decimation grid untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (in_valid) begin
            if (w_keep) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // Delay line of kept samples; r_dly[0] is the most recent. Zero start
    // makes the first M outputs equal to the raw kept samples, which is the
    // exact inverse of an accumulator that also started from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                r_dly[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < M; i++) begin
                r_dly[i] <= '0;
            end
        end else if (w_keep) begin
            r_dly[0] <= in;
            for (int i = 1; i < M; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Output stage. The subtraction wraps modulo 2^W so that wrap-around of
    // the upstream accumulator cancels exactly. clear drops the pulse but
    // leaves the last difference on `out`.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
        end else if (w_keep) begin
            r_out       <= in - r_dly[M-1];
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_comb_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_comb_decimator
// Description : Scoreboard bench for comb_decimator. Three instances with
//               different (R, M) share one stimulus stream; a reference model
//               keeps the list of kept samples per instance and queues the
//               expected differences, and a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comb_decimator;

    localparam int N = 3;
    localparam int RS [N] = '{4, 1, 2};
    localparam int MS [N] = '{1, 1, 2};
    localparam int KMAX = 1024;

    typedef struct {
        int          due;
        logic [31:0] v;
    } exp_t;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        clear    = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] din      = '0;
    logic        dvld [N];
    logic [31:0] dout [N];

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    exp_t        expq [N][$];
    int          acc  [N];
    int          nk   [N];
    logic [31:0] kept [N][KMAX];
    logic [31:0] hold [N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    comb_decimator #(.W(32), .R(4), .M(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in(din), .out_valid(dvld[0]), .out(dout[0]));
    comb_decimator #(.W(32), .R(1), .M(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in(din), .out_valid(dvld[1]), .out(dout[1]));
    comb_decimator #(.W(32), .R(2), .M(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in(din), .out_valid(dvld[2]), .out(dout[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: a restart forgets everything; the expected output of
    // a keep is the new sample minus the sample kept M keeps ago (or zero).
    task automatic model_restart(input bit full_reset);
        for (int d = 0; d < N; d++) begin
            acc[d] = 0;
            nk[d]  = 0;
            if (full_reset) begin
                expq[d].delete();
                hold[d] = '0;
            end
        end
    endtask

    task automatic model_accept(input logic [31:0] x);
        logic [31:0] prev;
        exp_t        e;
        for (int d = 0; d < N; d++) begin
            acc[d]++;
            if (acc[d] == RS[d]) begin
                acc[d] = 0;
                prev = (nk[d] >= MS[d]) ? kept[d][nk[d]-MS[d]] : 32'd0;
                if (nk[d] < KMAX) begin
                    kept[d][nk[d]] = x;
                    nk[d]++;
                end
                e.due = cyc + 1;
                e.v   = x - prev;
                expq[d].push_back(e);
            end
        end
    endtask

    // Apply one cycle of stimulus at the falling edge; the DUT samples it on
    // the next rising edge and the result is visible at the following negedge.
    task automatic drive(input bit v, input logic [31:0] x, input bit c);
        @(negedge clk);
        in_valid = v;
        din      = x;
        clear    = c;
        if (c) begin
            model_restart(1'b0);
        end else if (v) begin
            model_accept(x);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        for (int d = 0; d < N; d++) begin
            if (expq[d].size() > 0 && expq[d][0].due == cyc) begin
                e = expq[d].pop_front();
                chk($sformatf("out_valid[%0d] pulse", d), 32'(dvld[d]), 32'd1);
                chk($sformatf("out[%0d] value", d), dout[d], e.v);
                hold[d] = e.v;
            end else begin
                chk($sformatf("out_valid[%0d] idle", d), 32'(dvld[d]), 32'd0);
                chk($sformatf("out[%0d] hold", d), dout[d], hold[d]);
            end
        end
    endtask

    always @(negedge clk) mon_step();

    initial begin
        model_restart(1'b1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Running sum of 3: R=4 gives a steady 12.
        for (int k = 1; k <= 16; k++) drive(1'b1, 32'(3 * k), 1'b0);

        // Wrap-around of the upstream accumulator.
        drive(1'b0, 32'd0, 1'b1);
        drive(1'b1, 32'hFFFF_FFFE, 1'b0);
        drive(1'b1, 32'h0000_0002, 1'b0);

        // Ramp 1..10 exercises the M=2 delay.
        drive(1'b0, 32'd0, 1'b1);
        for (int k = 1; k <= 10; k++) drive(1'b1, 32'(k), 1'b0);

        // Gapped input.
        drive(1'b0, 32'd0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'(5 * k), 1'b0);
            drive(1'b0, 32'hDEAD_BEEF, 1'b0);
        end

        // clear wins over a simultaneous valid input.
        drive(1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 32'd1, 1'b0);
        drive(1'b1, 32'd99, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 32'd7, 1'b0);
        drive(1'b0, 32'd0, 1'b0);

        // Randomised traffic with occasional clears.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(9) < 7), $urandom, ($urandom_range(29) == 0));
        end

        // Asynchronous reset while a pulse is on the output.
        drive(1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, $urandom, 1'b0);
        @(posedge clk);
        #2;
        chk("pre-reset out_valid[0]", 32'(dvld[0]), 32'd1);
        in_valid = 1'b0;
        clear    = 1'b0;
        reset_n  = 1'b0;
        model_restart(1'b1);
        #1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("async reset out_valid[%0d]", d), 32'(dvld[d]), 32'd0);
            chk($sformatf("async reset out[%0d]", d), dout[d], 32'd0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) drive(1'b1, 32'(k * 11), 1'b0);

        repeat (3) drive(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("drain[%0d]", d), 32'(expq[d].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comb_decimator.md
# comb_decimator

Differentiating, decimating stage that undoes the running sum produced by the team's accumulator block. It keeps every R-th valid input word and outputs the difference between that sample and the sample kept M decimated periods earlier. Paired with an upstream accumulator, it forms the comb half of a one-stage CIC decimator. It sits between the integrator chain and the downstream filter/decimation logic.

## Interface

- W, 32: data width in bits; input and output use the same width.
- R, 4: decimation ratio; legal range R ≥ 1.
- M, 1: differential delay in decimated samples; legal range 1..4.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset. Asserting it clears all state immediately. Release is sampled on clk.
- clear  input  1  synchronous, active-high restart of the phase counter and delay line.
- in_valid  input  1  qualifies `in` for one cycle.
- in  input  W  integrated sample, interpreted modulo 2^W.
- out_valid  output  1  registered; single-cycle pulse per decimated output.
- out  output  W  registered difference, modulo 2^W; holds its last value between pulses.

## Operation

- State:
  - `phase`, a counter over 0..R-1, advanced only by accepted inputs (in_valid=1).
  - Delay line `d[0..M-1]`, each entry W bits; `d[0]` is the most recent kept sample.
  - Output registers `out` and `out_valid`.
- Reset (reset_n=0) values: phase=0, all d[i]=0, out=0, out_valid=0.
  - Zero-initialised delay makes the block the exact inverse of an accumulator that also reset to 0.
- Per rising edge, in priority order:
  1. clear=1: phase←0, all d[i]←0, out_valid←0, out unchanged. `in` is ignored even if in_valid=1.
  2. in_valid=1 and phase≠R-1: phase←phase+1, out_valid←0.
  3. in_valid=1 and phase=R-1 (the keep cycle):
     - phase←0.
     - out←in − d[M-1], mod 2^W.
     - out_valid←1.
     - Delay line shifts: d[0]←in, d[i]←d[i-1].
  4. in_valid=0: phase and delay line hold, out_valid←0.
- R=1: every valid input is a keep cycle and phase stays 0.
- Arithmetic:
  - Plain W-bit two's-complement subtraction; the borrow is discarded and there is no saturation.
  - Wrap-around of the upstream accumulator therefore cancels exactly. Example, W=32: 0x00000002 − 0xFFFFFFFE = 0x00000004.
- Gaps in in_valid do not disturb decimation; only accepted words are counted.
- No backpressure. The consumer must accept every out_valid pulse.

## Timing

- Latency: a keep-cycle input at edge t produces out/out_valid visible after edge t+1 (one register stage).
- out_valid is high for exactly one cycle per kept sample. Maximum output rate is one pulse per R accepted inputs.
  - With R=1 and continuous in_valid, out_valid stays high continuously.
- reset_n assertion mid-stream:
  - out_valid drops to 0 asynchronously, without waiting for a clock edge.
  - A pending keep cycle is lost.
  - The first keep after release is the R-th valid input after release.
- clear and in_valid in the same cycle: clear wins. The next accepted input counts as phase 0.
- After reset or clear, the first M outputs are differences against zero. They equal the raw kept samples; there is no output suppression.

## Test plan

- Inverse check, R=4, M=1:
  - Stimulus: in = 3, 6, 9, … (running sum of constant 3), in_valid continuous.
  - Required: out_valid pulses every 4th cycle, one cycle after the 4th, 8th, 12th inputs. out = 12, 12, 12, …
- Wrap-around, R=1, M=1:
  - Stimulus: in = 0xFFFFFFFE then 0x00000002.
  - Required: out = 0xFFFFFFFE, then 0x00000004.
- Differential delay, R=2, M=2:
  - Stimulus: in = 1, 2, …, 10 continuous.
  - Required: kept samples 2, 4, 6, 8, 10. out = 2, 4, 4, 4, 4.
- Gapped input, R=4:
  - Stimulus: in_valid toggled 1,0,1,0,… with in = 5, 10, 15, 20.
  - Required: a single out_valid one cycle after the 4th valid word, out = 20.
  - out_valid stays low during every gap cycle.
- clear priority:
  - Stimulus: after 3 valid inputs (R=4), assert clear together with in_valid=1.
  - Required: no output. The next 4 valid inputs (value 7 each) yield one out = 7, a difference against the zeroed delay line.
- Async reset:
  - Stimulus: assert reset_n low mid-cycle while out_valid=1.
  - Required: out_valid and out go to 0 before the next clk edge, and all counters restart from 0 after release.
